// File: rtl/ballot_scheduler.sv
// Polling-station ballot scheduler: tracks issued ballots per booth and grants
// one vote per cycle round-robin into a shared tally.
module ballot_scheduler #(
    parameter int N_BOOTH = 4,
    parameter int CNT_W   = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_open,
    input  logic                   i_close,
    input  logic [N_BOOTH-1:0]     i_issue,
    input  logic [N_BOOTH-1:0]     i_req,
    input  logic [2*N_BOOTH-1:0]   i_sel,
    output logic [N_BOOTH-1:0]     o_ready,
    output logic [N_BOOTH-1:0]     o_gnt,
    output logic [2:0]             o_inc,
    output logic [N_BOOTH-1:0]     o_reject,
    output logic [CNT_W-1:0]       o_cast,
    output logic [1:0]             o_state,
    output logic                   o_done
);

    localparam int PW = (N_BOOTH > 1) ? $clog2(N_BOOTH) : 1;
    localparam logic [CNT_W-1:0] CAST_MAX = '1;
    localparam logic [PW:0]      N_L      = (PW+1)'(N_BOOTH);
    localparam logic [PW-1:0]    LAST     = PW'(N_BOOTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        OPEN    = 2'b01,
        CLOSING = 2'b10,
        DONE    = 2'b11
    } state_t;

    state_t             state, state_next;
    logic [PW-1:0]      ptr, win;
    logic [PW:0]        scan;
    logic               found, active, forced, grant;
    logic [N_BOOTH-1:0] elig, rej_next, ready_next;
    logic [1:0]         win_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_open) state_next = OPEN;
            OPEN:    if (i_close) state_next = CLOSING;
            CLOSING: if (o_ready == '0 || i_close) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_state = state;
        o_done  = (state == DONE);
    end

    // A second close while draining is a forced close: ballots are voided.
    always_comb begin
        active = (state == OPEN) || (state == CLOSING);
        forced = (state == CLOSING) && i_close;
        for (int k = 0; k < N_BOOTH; k++) begin
            elig[k]     = active && i_req[k] && o_ready[k] && (|i_sel[2*k +: 2])
                          && (o_cast != CAST_MAX);
            rej_next[k] = active && i_req[k] && o_ready[k] && !(|i_sel[2*k +: 2]);
        end
    end

    // Scan booths starting at the round-robin pointer, wrapping at N_BOOTH.
    always_comb begin
        found = 1'b0;
        win   = '0;
        scan  = '0;
        for (int d = 0; d < N_BOOTH; d++) begin
            scan = {1'b0, ptr} + (PW+1)'(d);
            if (scan >= N_L) scan = scan - N_L;
            if (!found && elig[scan]) begin
                found = 1'b1;
                win   = scan[PW-1:0];
            end
        end
        grant    = found && !forced;
        win_code = i_sel[{win, 1'b0} +: 2];
    end

    always_comb begin
        ready_next = o_ready;
        if (state == OPEN) ready_next = o_ready | i_issue;
        if (grant) ready_next[win] = 1'b0;
        if (forced) ready_next = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_ready  <= '0;
            o_gnt    <= '0;
            o_inc    <= '0;
            o_reject <= '0;
            o_cast   <= '0;
            ptr      <= '0;
        end else begin
            o_ready  <= ready_next;
            o_reject <= rej_next;
            o_gnt    <= '0;
            o_inc    <= '0;
            if (grant) begin
                o_gnt  <= N_BOOTH'(1) << win;
                o_inc  <= 3'b001 << (win_code - 2'd1);
                o_cast <= o_cast + CNT_W'(1);
                ptr    <= (win == LAST) ? '0 : win + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ballot_scheduler.sv
// Directed and randomized bench for ballot_scheduler, checked against a
// behavioural model of the polling rules.
module tb_ballot_scheduler;

    localparam int NB       = 4;
    localparam int CAST_MAX = 63;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_open = 1'b0, i_close = 1'b0;
    logic [3:0] i_issue = '0, i_req = '0;
    logic [7:0] i_sel = '0;
    logic [3:0] o_ready, o_gnt, o_reject;
    logic [2:0] o_inc;
    logic [5:0] o_cast;
    logic [1:0] o_state;
    logic       o_done;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int       m_state, m_cast, m_ptr;
    bit [3:0] m_ready, e_gnt, e_rej;
    bit [2:0] e_inc;

    ballot_scheduler #(.N_BOOTH(4), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .i_open(i_open), .i_close(i_close),
        .i_issue(i_issue), .i_req(i_req), .i_sel(i_sel),
        .o_ready(o_ready), .o_gnt(o_gnt), .o_inc(o_inc), .o_reject(o_reject),
        .o_cast(o_cast), .o_state(o_state), .o_done(o_done)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("[TB] check %s", tag);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkEq({tag, ".state"},  32'(o_state),  32'(m_state));
        checkEq({tag, ".ready"},  32'(o_ready),  32'(m_ready));
        checkEq({tag, ".gnt"},    32'(o_gnt),    32'(e_gnt));
        checkEq({tag, ".inc"},    32'(o_inc),    32'(e_inc));
        checkEq({tag, ".reject"}, 32'(o_reject), 32'(e_rej));
        checkEq({tag, ".cast"},   32'(o_cast),   32'(m_cast));
        checkEq({tag, ".done"},   32'(o_done),   32'(m_state == 3));
    endtask

    function automatic void modelReset();
        m_state = 0; m_cast = 0; m_ptr = 0;
        m_ready = '0; e_gnt = '0; e_rej = '0; e_inc = '0;
    endfunction

    // Polling rules applied to the inputs driven this cycle
    function automatic void modelStep();
        bit active, forced;
        int win, win_code, code, k, nxt;
        active = (m_state == 1) || (m_state == 2);
        forced = (m_state == 2) && i_close;
        e_gnt = '0; e_rej = '0; e_inc = '0;
        win = -1; win_code = 0;
        for (int d = 0; d < NB; d++) begin
            k = (m_ptr + d) % NB;
            code = int'(i_sel[2*k +: 2]);
            if (active && i_req[k] && m_ready[k]) begin
                if (code == 0) e_rej[k] = 1'b1;
                else if (win < 0 && m_cast < CAST_MAX) begin
                    win = k;
                    win_code = code;
                end
            end
        end
        case (m_state)
            0: nxt = i_open ? 1 : 0;
            1: nxt = i_close ? 2 : 1;
            2: nxt = (m_ready == 0 || i_close) ? 3 : 2;
            default: nxt = 3;
        endcase
        if (m_state == 1) m_ready = m_ready | i_issue;
        if (forced) m_ready = '0;
        else if (win >= 0) begin
            m_ready[win] = 1'b0;
            m_cast++;
            m_ptr = (win + 1) % NB;
            e_gnt[win] = 1'b1;
            e_inc[win_code-1] = 1'b1;
        end
        m_state = nxt;
    endfunction

    task automatic applyStimulus(input string tag, input bit op, input bit cl,
                                 input bit [3:0] issue, input bit [3:0] req,
                                 input bit [7:0] sel);
        i_open = op; i_close = cl; i_issue = issue; i_req = req; i_sel = sel;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic resetDut(input string tag);
        i_open = 0; i_close = 0; i_issue = '0; i_req = '0; i_sel = '0;
        @(negedge clk);
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput(tag);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic bit [7:0] validSel();
        bit [7:0] s;
        for (int k = 0; k < NB; k++) s[2*k +: 2] = 2'($urandom_range(3, 1));
        return s;
    endfunction

    initial begin
        resetDut("reset0");
        applyStimulus("idle_ignore", 0, 1, 4'b1111, 4'b1111, 8'hFF);
        applyStimulus("open", 1, 0, 4'b0000, 4'b0000, 8'h00);

        // Four simultaneous requesters from pointer 0
        applyStimulus("issue_all", 0, 0, 4'b1111, 4'b0000, 8'h00);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("rr", 0, 0, 4'b0000, 4'b1111, 8'b11_10_01_11);
            checkEq("rr_order", 32'(o_gnt), 32'(1 << i));
        end
        checkEq("rr_ready", 32'(o_ready), 32'h0);
        checkEq("rr_cast", 32'(o_cast), 32'd4);

        applyStimulus("issue2", 0, 0, 4'b0100, 4'b0000, 8'h00);
        applyStimulus("vote2", 0, 0, 4'b0000, 4'b0100, 8'b00_10_00_00);
        checkEq("vote2_gnt", 32'(o_gnt), 32'b0100);
        checkEq("vote2_inc", 32'(o_inc), 32'b010);
        checkEq("vote2_cast", 32'(o_cast), 32'd5);

        applyStimulus("issue1", 0, 0, 4'b0010, 4'b0000, 8'h00);
        applyStimulus("invalid1", 0, 0, 4'b0000, 4'b0010, 8'h00);
        checkEq("invalid1_rej", 32'(o_reject), 32'b0010);
        checkEq("invalid1_ready", 32'(o_ready[1]), 32'd1);
        applyStimulus("valid1", 0, 0, 4'b0000, 4'b0010, 8'b00_00_11_00);
        checkEq("valid1_inc", 32'(o_inc), 32'b100);
        checkEq("valid1_rej", 32'(o_reject), 32'b0000);

        for (int i = 0; i < 150; i++)
            applyStimulus("rand_open", 1'($urandom), 0, 4'($urandom), 4'($urandom),
                          8'($urandom));

        // Fill the tally up to saturation
        for (int i = 0; i < 120 && m_cast < CAST_MAX; i++)
            applyStimulus("fill", 0, 0, 4'b1111, 4'b1111, validSel());
        checkEq("sat_reached", 32'(o_cast), 32'(CAST_MAX));
        applyStimulus("sat_issue", 0, 0, 4'b0001, 4'b0000, 8'h00);
        applyStimulus("sat_req", 0, 0, 4'b0000, 4'b0001, 8'b00_00_00_01);
        checkEq("sat_gnt", 32'(o_gnt), 32'h0);
        checkEq("sat_cast", 32'(o_cast), 32'(CAST_MAX));
        checkEq("sat_keep", 32'(o_ready[0]), 32'd1);

        // Close, drain one vote, then force the close
        resetDut("reset_close");
        applyStimulus("open_c", 1, 0, 4'b0000, 4'b0000, 8'h00);
        applyStimulus("issue03", 0, 0, 4'b1001, 4'b0000, 8'h00);
        applyStimulus("close1", 0, 1, 4'b0000, 4'b0000, 8'h00);
        checkEq("close1_state", 32'(o_state), 32'b10);
        applyStimulus("closing_vote", 0, 0, 4'b0110, 4'b0001, 8'b00_00_00_01);
        checkEq("closing_ready", 32'(o_ready), 32'b1000);
        applyStimulus("close2", 0, 1, 4'b0000, 4'b1000, 8'b01_00_00_00);
        checkEq("forced_ready", 32'(o_ready), 32'h0);
        checkEq("forced_gnt", 32'(o_gnt), 32'h0);
        checkEq("forced_state", 32'(o_state), 32'b11);
        applyStimulus("done_open", 1, 0, 4'b1111, 4'b1111, 8'hFF);
        checkEq("done_sticky", 32'(o_done), 32'd1);

        // Reset while ballots are outstanding
        resetDut("reset_pre");
        applyStimulus("open_r", 1, 0, 4'b0000, 4'b0000, 8'h00);
        applyStimulus("issue13", 0, 0, 4'b1010, 4'b0000, 8'h00);
        resetDut("reset_mid");

        for (int r = 0; r < 3; r++) begin
            resetDut("reset_rand");
            for (int i = 0; i < 80; i++)
                applyStimulus("rand_flow", $urandom_range(3) == 0, $urandom_range(15) == 0,
                              4'($urandom), 4'($urandom), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ballot_scheduler.md
BALLOT_SCHEDULER -- requirements
Module: ballot_scheduler

Interface
REQ-001 Parameter: N_BOOTH, 4, number of voting booths sharing one tally datapath.
REQ-002 Parameter: CNT_W, 6, width of the total-ballots-cast counter.
REQ-003 Clocking and reset: one clock, clk; reset rst is asynchronous and active-high.
REQ-004 Port: clk  input  1  system clock, all state changes on its rising edge.
REQ-005 Port: rst  input  1  asynchronous active-high reset.
REQ-006 Port: i_open  input  1  presiding officer opens the poll.
REQ-007 Port: i_close  input  1  presiding officer closes the poll (first assertion); a second assertion forces the close.
REQ-008 Port: i_issue  input  N_BOOTH  per-booth ballot issue strobe.
REQ-009 Port: i_req  input  N_BOOTH  per-booth vote-cast request, level.
REQ-010 Port: i_sel  input  2*N_BOOTH  candidate code per booth, bits [2k+1:2k]; 01/10/11 = candidate 1/2/3, 00 invalid.
REQ-011 Port: o_ready  output  N_BOOTH  booth holds an unused ballot.
REQ-012 Port: o_gnt  output  N_BOOTH  one-hot one-cycle grant pulse to the booth whose vote was accepted.
REQ-013 Port: o_inc  output  3  one-hot one-cycle increment strobe to the tally for candidates 1..3.
REQ-014 Port: o_reject  output  N_BOOTH  one-cycle pulse for each booth that requested with an invalid code.
REQ-015 Port: o_cast  output  CNT_W  total accepted votes.
REQ-016 Port: o_state  output  2  FSM state: IDLE=00, OPEN=01, CLOSING=10, DONE=11.
REQ-017 Port: o_done  output  1  high when state is DONE.

Function
REQ-018 IDLE: i_open=1 moves the FSM to OPEN on the next edge; i_close and i_issue are ignored in IDLE.
REQ-019 OPEN: i_issue[k]=1 sets o_ready[k] on the next edge; issuing to a booth that is already ready has no effect.
REQ-020 OPEN: i_close=1 moves the FSM to CLOSING on the next edge; issues presented in that same cycle are still honoured.
REQ-021 CLOSING: i_issue is ignored, and booths that already hold a ballot may still vote.
REQ-022 CLOSING to DONE transition: occurs on the edge after o_ready reaches all-zero, or on the edge after i_close is asserted again.
REQ-023 Forced close: that same edge clears every o_ready bit and no grant is issued.
REQ-024 DONE is sticky until rst; all inputs are ignored and o_done=1.
REQ-025 Eligibility: booth k is eligible in a cycle when state is OPEN or CLOSING, i_req[k]=1, o_ready[k]=1, i_sel code for k is non-zero, and o_cast is below 2^CNT_W-1.
REQ-026 Grant count: at most one eligible booth is granted per cycle, chosen round-robin starting at the booth after the last granted booth; the pointer resets to booth 0 as highest priority.
REQ-027 Grant timing: registered, so on the edge after the eligible cycle o_gnt[k]=1, o_inc carries the decoded candidate of booth k as sampled in the eligible cycle, o_ready[k]=0, and o_cast increments by 1.
REQ-028 Grant latency: exactly one clock from eligible request to o_gnt/o_inc; both are zero in every other cycle.
REQ-029 Non-granted eligible booths keep their ballot and compete again in the following cycle.
REQ-030 Invalid code: i_req[k]=1 with o_ready[k]=1 and code 00 pulses o_reject[k] one cycle later and keeps the ballot; several booths may be rejected in the same cycle, independent of arbitration.
REQ-031 Issue vs grant collision: when an issue and a grant hit the same booth in the same cycle, the grant wins and o_ready[k] ends at 0.
REQ-032 Saturation: when o_cast equals 2^CNT_W-1 no further grants are issued; o_cast never wraps and requests remain pending.
REQ-033 Requests from booths without a ballot are ignored, with no grant and no reject.

Reset
REQ-034 rst=1 at any time asynchronously forces: state IDLE, o_ready=0, o_gnt=0, o_inc=0, o_reject=0, o_cast=0, o_done=0, round-robin pointer to booth 0.
REQ-035 A reset during OPEN or CLOSING discards all ballots; on release the block waits in IDLE for i_open.

Verification
REQ-036 Scenario: open, issue booth 2, i_req[2] with code 10 -> one cycle later o_gnt=0100, o_inc=010, o_ready[2]=0, o_cast=1.
REQ-037 Scenario: all 4 booths ready, all request with valid codes, held -> grants in order 0,1,2,3 on four consecutive cycles, o_cast=4, o_ready=0000.
REQ-038 Scenario: booth 1 requests with code 00 -> o_reject=0010 for one cycle, o_ready[1] stays 1; then code 11 -> o_inc=100.
REQ-039 Scenario: booths 0 and 3 ready, i_close; booth 0 votes, then i_close again -> o_ready=0000 and state DONE; later i_open is ignored.
REQ-040 Scenario: preload o_cast to 63 through votes, then a valid request -> no o_gnt, o_cast stays 63, ballot retained.
REQ-041 Scenario: assert rst mid-OPEN with 2 ballots outstanding -> immediately o_ready=0, o_cast=0, o_state=00.
